// File: rtl/hsv_seq_pkg.sv
// hsv_seq_pkg: shared widths and sequencer state encoding for the HSV pixel path.
package hsv_seq_pkg;
    localparam int PIX_W = 16;
    localparam int HUE_W = 9;
    localparam int CH_W  = 5;
    localparam int WD_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ARM,
        S_BUSY,
        S_EMIT,
        S_RECOVER
    } state_e;
endpackage

// File: rtl/pix_fifo.sv
// pix_fifo: synchronous first-word-fall-through FIFO with registered occupancy.
module pix_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         res,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic          wr, rd;

    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign rd    = pop & ~empty;
    assign wr    = push & (~full | rd);
    assign dout  = mem_q[rp_q];

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (wr) mem_q[wp_q] <= din;
            wp_q  <= wp_q + AW'(wr);
            rp_q  <= rp_q + AW'(rd);
            cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
endmodule

// File: rtl/hsv_pixel_sequencer.sv
// hsv_pixel_sequencer: buffers coordinate-tagged pixels and runs them one at a time
// through the multicycle HSV converter, resetting the converter if it hangs.
module hsv_pixel_sequencer
    import hsv_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 640,
    parameter int XW         = 10,
    parameter int YW         = 9,
    parameter int TIMEOUT    = 32
) (
    input  logic             clk,
    input  logic             res,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_data,
    input  logic             in_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [HUE_W-1:0] out_hue,
    output logic [CH_W-1:0]  out_sat,
    output logic [CH_W-1:0]  out_val,
    output logic             out_hue_invalid,
    output logic [XW-1:0]    out_x,
    output logic [YW-1:0]    out_y,
    output logic             conv_read,
    output logic [PIX_W-1:0] conv_data,
    output logic             conv_res,
    input  logic             conv_done,
    input  logic [HUE_W-1:0] conv_hue,
    input  logic [CH_W-1:0]  conv_sat,
    input  logic [CH_W-1:0]  conv_val,
    input  logic             conv_hue_invalid,
    output logic             timeout_err
);
    localparam int EW = PIX_W + XW + YW;
    localparam int OW = 1 + HUE_W + 2 * CH_W + XW + YW;

    state_e          state_q, state_d;
    logic [EW-1:0]   hold_q, hold_d, f_dout;
    logic [OW-1:0]   out_q, out_d;
    logic [XW-1:0]   x_q, x_d, tag_x;
    logic [YW-1:0]   y_q, y_d, tag_y;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            rec_q, err_q, err_d, read_q, valid_q;
    logic            accept, pop, f_full, f_empty, x_wrap, in_conv, expire, done_busy;

    assign accept = in_valid & in_ready;
    assign tag_x  = in_sof ? '0 : x_q;
    assign tag_y  = in_sof ? '0 : y_q;
    assign x_wrap = tag_x == XW'(WIDTH - 1);
    assign x_d    = accept ? (x_wrap ? '0 : tag_x + 1'b1) : x_q;
    assign y_d    = accept ? tag_y + YW'(x_wrap) : y_q;

    pix_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .res   (res),
        .push  (accept),
        .pop   (pop),
        .din   ({in_data, tag_x, tag_y}),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty)
    );

    assign in_conv   = state_q == S_ARM || state_q == S_BUSY;
    assign done_busy = state_q == S_BUSY && conv_done;
    // ARM+BUSY get exactly TIMEOUT cycles; a done on the last of them still wins.
    assign expire    = in_conv && wd_q == WD_W'(TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE:    begin pop = !f_empty; state_d = f_empty ? S_IDLE : S_ISSUE; end
            S_ISSUE:   state_d = S_ARM;
            S_ARM:     state_d = expire ? S_RECOVER : (conv_done ? S_ARM : S_BUSY);
            S_BUSY:    state_d = done_busy ? S_EMIT : (expire ? S_RECOVER : S_BUSY);
            S_EMIT:    if (out_ready) begin pop = !f_empty; state_d = f_empty ? S_IDLE : S_ISSUE; end
            S_RECOVER: state_d = rec_q ? S_IDLE : S_RECOVER;
            default:   state_d = S_IDLE;
        endcase
        hold_d = pop ? f_dout : hold_q;
        wd_d   = in_conv ? wd_q + 1'b1 : '0;
        err_d  = err_q | (expire & ~done_busy);
        out_d  = done_busy ? {conv_hue_invalid, conv_hue, conv_sat, conv_val, hold_q[XW+YW-1:0]} : out_q;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            out_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            wd_q    <= '0;
            rec_q   <= 1'b0;
            err_q   <= 1'b0;
            read_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
            x_q     <= x_d;
            y_q     <= y_d;
            wd_q    <= wd_d;
            rec_q   <= state_q == S_RECOVER;
            err_q   <= err_d;
            read_q  <= state_d == S_ISSUE;
            valid_q <= state_d == S_EMIT;
        end
    end

    assign in_ready    = !f_full && !res;
    assign {out_hue_invalid, out_hue, out_sat, out_val, out_x, out_y} = out_q;
    assign out_valid   = valid_q;
    assign conv_read   = read_q;
    assign conv_data   = hold_q[EW-1 -: PIX_W];
    assign conv_res    = res || state_q == S_RECOVER;
    assign timeout_err = err_q;
endmodule
